// File: rtl/eth_speed_pkg.sv
// Shared encodings for the GMII/MII receive speed sequencer.
package eth_speed_pkg;

    localparam logic [1:0] SPEED_10   = 2'd0;
    localparam logic [1:0] SPEED_100  = 2'd1;
    localparam logic [1:0] SPEED_1000 = 2'd2;
    localparam logic [1:0] SPEED_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } speed_state_t;

    // 10M and 100M both run the receiver in nibble (MII) mode.
    function automatic logic is_mii(input logic [1:0] speed);
        return speed != SPEED_1000;
    endfunction

endpackage

// File: rtl/axis_gmii_rx_speed_ctrl_if.sv
// Control bundle between link management, the speed sequencer and the GMII receiver.
interface axis_gmii_rx_speed_ctrl_if;

    logic [1:0] cfg_speed;
    logic       gmii_rx_dv;
    logic       clk_enable;
    logic       mii_select;
    logic [1:0] speed_active;
    logic       switch_busy;
    logic       switch_done;

    modport master (
        output cfg_speed, gmii_rx_dv,
        input  clk_enable, mii_select, speed_active, switch_busy, switch_done
    );

    modport slave (
        input  cfg_speed, gmii_rx_dv,
        output clk_enable, mii_select, speed_active, switch_busy, switch_done
    );

endinterface

// File: rtl/eth_clk_enable_gen.sv
// Receiver clock-enable prescaler: one enable every `period` cycles, or every
// cycle in bypass. After `clear` the first enable lands on the following cycle.
module eth_clk_enable_gen #(
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic                 clear,
    input  logic                 bypass,
    output logic                 enable
);

    logic [CNT_WIDTH-1:0] cnt;

    // Down-counter from period-1; terminal count 0 emits the enable and reloads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            enable <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            enable <= 1'b0;
        end else if (bypass) begin
            cnt    <= '0;
            enable <= 1'b1;
        end else begin
            enable <= (cnt == '0);
            cnt    <= (cnt == '0) ? period - 1'b1 : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/axis_gmii_rx_speed_ctrl.sv
// Speed sequencer for the GMII/MII receiver: applies 10/100/1000 changes only
// after an idle gap on gmii_rx_dv, so a frame is never cut mid-way.
//
//   state  | meaning
//   RUN    | current speed applied, watching for a new request
//   DRAIN  | change pending, waiting for IDLE_GAP idle enables on rx_dv
//   SWITCH | one cycle: receiver gated off, new speed loaded
module axis_gmii_rx_speed_ctrl
    import eth_speed_pkg::*;
#(
    parameter int PRESCALE_100 = 5,
    parameter int PRESCALE_10  = 50,
    parameter int IDLE_GAP     = 12,
    parameter int CNT_WIDTH    = 6
) (
    input logic                      clk,
    input logic                      rst_n,
    axis_gmii_rx_speed_ctrl_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] P100 = CNT_WIDTH'(PRESCALE_100);
    localparam logic [CNT_WIDTH-1:0] P10  = CNT_WIDTH'(PRESCALE_10);
    localparam logic [CNT_WIDTH-1:0] GAP  = CNT_WIDTH'(IDLE_GAP);

    speed_state_t         state;
    logic [1:0]           cfg;
    logic                 rx_dv;
    logic [1:0]           speed_q;
    logic [1:0]           target;
    logic                 mii_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CNT_WIDTH-1:0] idle_cnt;
    logic                 clk_en;
    logic [1:0]           eff_target;
    logic                 enter_switch;
    logic [CNT_WIDTH-1:0] period;
    logic                 bypass;

    assign cfg   = bus.cfg_speed;
    assign rx_dv = bus.gmii_rx_dv;

    // Switch decision; a late request in the exit cycle wins over the old target,
    // and dv seen in that same cycle vetoes the switch.
    always_comb begin
        eff_target   = (cfg != SPEED_RSVD) ? cfg : target;
        enter_switch = (state == ST_DRAIN) && (cfg != speed_q) &&
                       (idle_cnt >= GAP) && !rx_dv;
        period       = (speed_q == SPEED_10) ? P10 : P100;
        bypass       = (speed_q == SPEED_1000);
    end

    // Sequencer state and its registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            speed_q <= SPEED_1000;
            target  <= SPEED_1000;
            mii_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (cfg != SPEED_RSVD && cfg != speed_q) begin
                        target <= cfg;
                        state  <= ST_DRAIN;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    target <= eff_target;
                    if (cfg == speed_q) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b0;
                    end else if (enter_switch) begin
                        state   <= ST_SWITCH;
                        speed_q <= eff_target;
                        mii_q   <= is_mii(eff_target);
                        done_q  <= 1'b1;
                    end
                end
                ST_SWITCH: begin
                    state  <= ST_RUN;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_RUN;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Idle gap counter: counts enabled idle cycles, any dv restarts the gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (rx_dv || enter_switch) begin
            idle_cnt <= '0;
        end else if (clk_en && idle_cnt < GAP) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    eth_clk_enable_gen #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_clk_enable_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .period (period),
        .clear  (enter_switch),
        .bypass (bypass),
        .enable (clk_en)
    );

    assign bus.clk_enable   = clk_en;
    assign bus.mii_select   = mii_q;
    assign bus.speed_active = speed_q;
    assign bus.switch_busy  = busy_q;
    assign bus.switch_done  = done_q;

endmodule
